// File: rtl/kmx_mac_pkg.sv
// rtl/kmx_mac_pkg.sv - shared KMX/EMAC constants and receive-DMA state encoding
package kmx_mac_pkg;

    localparam int PAW = 11;

    localparam logic [PAW-1:0] EMAC_BASE_ADDR    = 11'h080;
    localparam logic [PAW-1:0] EMAC_DMASTAT_ADDR = 11'h087;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } rxdma_state_t;

endpackage

// File: rtl/kmx_mac_rxdma_if.sv
// rtl/kmx_mac_rxdma_if.sv - KMX/DMA bus and MAC receive-buffer signals of the receive DMA
interface kmx_mac_rxdma_if
    import kmx_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 11
);
    logic [PAW-1:0]        periph_adr_i;
    logic                  sedrd_i;
    logic [1:0]            grant_dma_i;
    logic                  dma_req_rd_i;
    logic [1:0]            req_dma_o;
    logic [1:0]            hold_dma_o;
    logic [DATA_WIDTH-1:0] rd_data_o;

    logic                  rx_frame_rdy_i;
    logic [LEN_WIDTH-1:0]  rx_len_i;
    logic [DATA_WIDTH-1:0] rx_word_i;
    logic                  rx_valid_i;
    logic                  rx_pop_o;

    // master: the KMX bus/DMA engine and MAC buffer; slave: the receive DMA block
    modport master (
        output periph_adr_i, sedrd_i, grant_dma_i, dma_req_rd_i,
        output rx_frame_rdy_i, rx_len_i, rx_word_i, rx_valid_i,
        input  req_dma_o, hold_dma_o, rd_data_o, rx_pop_o
    );

    modport slave (
        input  periph_adr_i, sedrd_i, grant_dma_i, dma_req_rd_i,
        input  rx_frame_rdy_i, rx_len_i, rx_word_i, rx_valid_i,
        output req_dma_o, hold_dma_o, rd_data_o, rx_pop_o
    );

endinterface

// File: rtl/kmx_mac_rxdma.sv
// rtl/kmx_mac_rxdma.sv - moves one MAC receive frame to KMX via DMA, with clear-on-read status
module kmx_mac_rxdma
    import kmx_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 11,
    parameter logic [PAW-1:0] EMAC_DMASTAT_ADDR = kmx_mac_pkg::EMAC_DMASTAT_ADDR
)(
    input  logic           sysclk_i,
    input  logic           reset_i,
    kmx_mac_rxdma_if.slave bus,
    output logic           frame_done_o,
    output logic           err_o
);

    rxdma_state_t          state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  err_q;

    logic frame_accept, strobe, pop, underrun, stat_rd;
    logic req, hold;
    logic unused_grant_hi;

    assign unused_grant_hi = bus.grant_dma_i[1];

    assign frame_accept = (state_q == IDLE) && bus.rx_frame_rdy_i && (bus.rx_len_i != '0);
    assign strobe       = (state_q == XFER) && bus.dma_req_rd_i;
    assign pop          = strobe && bus.rx_valid_i && (cnt_q != '0);
    assign underrun     = strobe && !bus.rx_valid_i;
    // The DMA path owns rd_data during XFER, so status reads there are dropped.
    assign stat_rd      = !bus.sedrd_i && (bus.periph_adr_i == EMAC_DMASTAT_ADDR)
                          && (state_q != XFER);

    always_ff @(posedge sysclk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (frame_accept) state_d = REQ;
            REQ:  if (bus.grant_dma_i[0]) state_d = XFER;
            XFER: begin
                if (underrun) begin
                    state_d = DONE;
                end else if (pop && (cnt_q == LEN_WIDTH'(1))) begin
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else if (!bus.grant_dma_i[0]) begin
                    state_d = REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req          = 1'b0;
        hold         = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            REQ:  req = 1'b1;
            XFER: begin
                req  = 1'b1;
                hold = 1'b1;
            end
            DONE:    frame_done_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.req_dma_o  = {1'b0, req};
    assign bus.hold_dma_o = {1'b0, hold};
    assign bus.rx_pop_o   = pop;
    assign bus.rd_data_o  = rd_data_q;
    assign err_o          = err_q;

    always_ff @(posedge sysclk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q     <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (frame_accept) begin
                cnt_q <= bus.rx_len_i;
            end else if (pop) begin
                cnt_q <= cnt_q - LEN_WIDTH'(1);
            end

            if (pop) begin
                rd_data_q <= bus.rx_word_i;
            end else if (stat_rd) begin
                rd_data_q <= DATA_WIDTH'({err_q, state_q, cnt_q});
            end

            // A new underrun wins over a clear from a coincident status read.
            if (underrun) begin
                err_q <= 1'b1;
            end else if (stat_rd) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kmx_mac_rxdma.sv
// tb/tb_kmx_mac_rxdma.sv - directed self-checking bench for kmx_mac_rxdma
module tb_kmx_mac_rxdma;
    import kmx_mac_pkg::*;

    logic sysclk_i;
    logic reset_i;
    logic frame_done_o;
    logic err_o;

    int checks = 0;
    int errors = 0;

    kmx_mac_rxdma_if #(.DATA_WIDTH(32), .LEN_WIDTH(11)) bus ();

    kmx_mac_rxdma #(
        .DATA_WIDTH(32),
        .LEN_WIDTH(11),
        .EMAC_DMASTAT_ADDR(11'h087)
    ) dut (
        .sysclk_i    (sysclk_i),
        .reset_i     (reset_i),
        .bus         (bus),
        .frame_done_o(frame_done_o),
        .err_o       (err_o)
    );

    initial sysclk_i = 1'b0;
    always #5 sysclk_i = ~sysclk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk_i);
        #1;
    endtask

    task automatic stat_read(input string tag, input logic [31:0] exp);
        bus.sedrd_i      = 1'b0;
        bus.periph_adr_i = 11'h087;
        tick();
        bus.sedrd_i      = 1'b1;
        bus.periph_adr_i = '0;
        chk(tag, bus.rd_data_o, exp);
    endtask

    task automatic start_frame(input logic [10:0] len);
        bus.rx_frame_rdy_i = 1'b1;
        bus.rx_len_i       = len;
        tick();
        bus.rx_frame_rdy_i = 1'b0;
        bus.rx_len_i       = '0;
    endtask

    task automatic strobe_word(input string tag, input logic [31:0] word);
        bus.dma_req_rd_i = 1'b1;
        bus.rx_valid_i   = 1'b1;
        bus.rx_word_i    = word;
        #1;
        chk({tag, "_pop"}, {31'd0, bus.rx_pop_o}, 32'd1);
        tick();
        chk({tag, "_data"}, bus.rd_data_o, word);
    endtask

    initial begin
        reset_i            = 1'b0;
        bus.periph_adr_i   = '0;
        bus.sedrd_i        = 1'b1;
        bus.grant_dma_i    = 2'b00;
        bus.dma_req_rd_i   = 1'b0;
        bus.rx_frame_rdy_i = 1'b0;
        bus.rx_len_i       = '0;
        bus.rx_word_i      = '0;
        bus.rx_valid_i     = 1'b0;

        repeat (3) tick();
        chk("rst_req",  {30'd0, bus.req_dma_o},  32'd0);
        chk("rst_hold", {30'd0, bus.hold_dma_o}, 32'd0);
        chk("rst_data", bus.rd_data_o, 32'd0);
        chk("rst_done", {31'd0, frame_done_o}, 32'd0);
        chk("rst_err",  {31'd0, err_o}, 32'd0);
        reset_i = 1'b1;
        tick();
        stat_read("idle_stat_after_rst", 32'h0000_0000);

        // zero-length frame is ignored
        start_frame(11'd0);
        chk("len0_req", {30'd0, bus.req_dma_o}, 32'd0);
        stat_read("len0_stat", 32'h0000_0000);

        // normal 4-word transfer, grant after 3 cycles
        start_frame(11'd4);
        chk("norm_req", {30'd0, bus.req_dma_o}, 32'd1);
        chk("norm_hold_pre", {30'd0, bus.hold_dma_o}, 32'd0);
        tick();
        tick();
        chk("norm_req_wait", {30'd0, bus.req_dma_o}, 32'd1);
        bus.grant_dma_i = 2'b01;
        tick();
        chk("norm_hold", {30'd0, bus.hold_dma_o}, 32'd1);
        bus.sedrd_i      = 1'b0;
        bus.periph_adr_i = 11'h087;
        strobe_word("norm_w0_prio", 32'hA000_00A0);
        bus.sedrd_i      = 1'b1;
        bus.periph_adr_i = '0;
        for (int i = 1; i < 4; i++) begin
            strobe_word("norm_w", 32'hA000_00A0 + i);
        end
        bus.dma_req_rd_i = 1'b0;
        bus.rx_valid_i   = 1'b0;
        chk("norm_done", {31'd0, frame_done_o}, 32'd1);
        chk("norm_done_req", {30'd0, bus.req_dma_o}, 32'd0);
        chk("norm_done_hold", {30'd0, bus.hold_dma_o}, 32'd0);
        chk("norm_done_pop", {31'd0, bus.rx_pop_o}, 32'd0);
        tick();
        chk("norm_done_once", {31'd0, frame_done_o}, 32'd0);
        stat_read("norm_stat_idle", 32'h0000_0000);

        // underrun on 2nd strobe of a 3-word frame
        start_frame(11'd3);
        tick();
        strobe_word("und_w0", 32'hB000_00B0);
        bus.rx_valid_i = 1'b0;
        #1;
        chk("und_no_pop", {31'd0, bus.rx_pop_o}, 32'd0);
        tick();
        bus.dma_req_rd_i = 1'b0;
        chk("und_err", {31'd0, err_o}, 32'd1);
        chk("und_done", {31'd0, frame_done_o}, 32'd1);
        tick();
        bus.grant_dma_i = 2'b00;
        chk("und_err_hold", {31'd0, err_o}, 32'd1);
        stat_read("und_stat", 32'h0000_2002);
        chk("und_err_clr", {31'd0, err_o}, 32'd0);

        // grant loss after 2 of 5 words
        start_frame(11'd5);
        bus.grant_dma_i = 2'b01;
        tick();
        strobe_word("gl_w0", 32'hC000_0000);
        strobe_word("gl_w1", 32'hC000_0001);
        bus.dma_req_rd_i = 1'b0;
        bus.rx_valid_i   = 1'b0;
        bus.grant_dma_i  = 2'b00;
        chk("gl_hold_same", {30'd0, bus.hold_dma_o}, 32'd1);
        tick();
        chk("gl_hold_drop", {30'd0, bus.hold_dma_o}, 32'd0);
        chk("gl_req_kept", {30'd0, bus.req_dma_o}, 32'd1);
        stat_read("gl_stat", 32'h0000_0803);
        bus.dma_req_rd_i = 1'b1;
        bus.rx_valid_i   = 1'b1;
        bus.rx_word_i    = 32'hDEAD_BEEF;
        #1;
        chk("gl_req_strobe_pop", {31'd0, bus.rx_pop_o}, 32'd0);
        tick();
        chk("gl_req_strobe_data", bus.rd_data_o, 32'h0000_0803);
        bus.dma_req_rd_i = 1'b0;
        bus.rx_valid_i   = 1'b0;
        bus.grant_dma_i  = 2'b01;
        tick();
        bus.rx_frame_rdy_i = 1'b1;
        bus.rx_len_i       = 11'd9;
        strobe_word("gl_w2", 32'hC000_0002);
        bus.rx_frame_rdy_i = 1'b0;
        bus.rx_len_i       = '0;
        strobe_word("gl_w3", 32'hC000_0003);
        strobe_word("gl_w4", 32'hC000_0004);
        bus.dma_req_rd_i = 1'b0;
        bus.rx_valid_i   = 1'b0;
        chk("gl_done", {31'd0, frame_done_o}, 32'd1);
        tick();
        bus.grant_dma_i = 2'b00;
        chk("gl_idle_req", {30'd0, bus.req_dma_o}, 32'd0);

        // asynchronous reset in XFER with cnt=7
        start_frame(11'd7);
        bus.grant_dma_i = 2'b01;
        tick();
        bus.dma_req_rd_i = 1'b1;
        bus.rx_valid_i   = 1'b1;
        bus.rx_word_i    = 32'hE000_00E0;
        #1;
        chk("rst7_pop_pre", {31'd0, bus.rx_pop_o}, 32'd1);
        reset_i = 1'b0;
        #1;
        chk("rst7_req",  {30'd0, bus.req_dma_o},  32'd0);
        chk("rst7_hold", {30'd0, bus.hold_dma_o}, 32'd0);
        chk("rst7_pop",  {31'd0, bus.rx_pop_o},   32'd0);
        chk("rst7_data", bus.rd_data_o, 32'd0);
        chk("rst7_done", {31'd0, frame_done_o}, 32'd0);
        bus.dma_req_rd_i = 1'b0;
        bus.rx_valid_i   = 1'b0;
        bus.grant_dma_i  = 2'b00;
        tick();
        reset_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst7_no_done", {31'd0, frame_done_o}, 32'd0);
        end
        stat_read("rst7_stat", 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kmx_mac_rxdma.md
KMX_MAC_RXDMA -- requirements
Module: kmx_mac_rxdma

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the KMX data bus and of MAC receive words.
REQ-002 Parameter LEN_WIDTH, default 11: width of the frame length in words.
REQ-003 Parameter EMAC_DMASTAT_ADDR, default 'h87: KMX address of the read-only DMA status register.
REQ-004 Port sysclk_i, input, 1: system clock; all logic is on the rising edge.
REQ-005 Port reset_i, input, 1: reset, asynchronous, active-low.
REQ-006 Port periph_adr_i, input, PAW (11): KMX address bus.
REQ-007 Port sedrd_i, input, 1: KMX read strobe, active-low.
REQ-008 Port grant_dma_i, input, 2: DMA grant; bit 0 is the receive channel.
REQ-009 Port dma_req_rd_i, input, 1: DMA word-read cycle, active-high.
REQ-010 Port req_dma_o, output, 2: DMA request; only bit 0 is used, bit 1 is tied to 0.
REQ-011 Port hold_dma_o, output, 2: DMA bus hold; only bit 0 is used, bit 1 is tied to 0.
REQ-012 Port rd_data_o, output, DATA_WIDTH: registered read data to KMX/DMA.
REQ-013 Port rx_frame_rdy_i, input, 1: one-cycle pulse meaning the MAC holds a complete frame.
REQ-014 Port rx_len_i, input, LEN_WIDTH: frame length in words; valid with rx_frame_rdy_i.
REQ-015 Port rx_word_i, input, DATA_WIDTH: head word of the MAC receive buffer.
REQ-016 Port rx_valid_i, input, 1: rx_word_i is valid.
REQ-017 Port rx_pop_o, output, 1: one-cycle pulse that advances the MAC receive buffer.
REQ-018 Port frame_done_o, output, 1: one-cycle pulse on frame completion.
REQ-019 Port err_o, output, 1: sticky underrun error flag.

Function
REQ-020 The state machine SHALL have the states IDLE, REQ, XFER and DONE.
REQ-021 IDLE: on rx_frame_rdy_i with rx_len_i != 0, latch rx_len_i into cnt and go to REQ; a zero length SHALL be ignored.
REQ-022 REQ: req_dma_o[0]=1; when grant_dma_i[0]=1, go to XFER.
REQ-023 XFER: req_dma_o[0]=1 and hold_dma_o[0]=1.
REQ-024 XFER, on dma_req_rd_i=1 with rx_valid_i=1: rd_data_o<=rx_word_i, rx_pop_o=1 in the same cycle, cnt<=cnt-1; this gives one-cycle latency from strobe to data.
REQ-025 XFER, on dma_req_rd_i=1 with rx_valid_i=0: set err_o, pop nothing, and go to DONE (abort).
REQ-026 XFER: when the decrement makes cnt 0, go to DONE in the next cycle.
REQ-027 XFER, if grant_dma_i[0] drops with cnt!=0: return to REQ, retaining cnt, with hold_dma_o[0]=0 from the next cycle.
REQ-028 DONE: req/hold=0 and frame_done_o=1 for exactly one cycle, then go to IDLE.
REQ-029 rx_frame_rdy_i outside IDLE SHALL be ignored; the MAC re-asserts it after frame_done_o.
REQ-030 A status read, defined as sedrd_i=0 and periph_adr_i==EMAC_DMASTAT_ADDR in a non-XFER state, SHALL load rd_data_o next cycle with {zero-pad, err_o, state[1:0], cnt[LEN_WIDTH-1:0]}, cnt at bits 10:0.
REQ-031 A status read during XFER SHALL be ignored, and the DMA path has priority.
REQ-032 err_o SHALL be cleared only by a status read (clear-on-read, effective the cycle after the read) or by reset; a simultaneous set has priority over the clear.
REQ-033 cnt SHALL never wrap below 0, and dma_req_rd_i outside XFER SHALL have no effect.

Reset
REQ-034 Asynchronous reset_i=0 SHALL force state=IDLE, cnt=0, rd_data_o=0, req_dma_o=0, hold_dma_o=0, rx_pop_o=0, frame_done_o=0 and err_o=0.
REQ-035 Reset mid-transfer SHALL discard the frame with no frame_done_o pulse, and the receive buffer is not popped further.

Structure
REQ-036 The shared package kmx_mac_pkg SHALL hold PAW, the EMAC_* address constants (including EMAC_DMASTAT_ADDR), and the state enum rxdma_state_t encoded IDLE=0, REQ=1, XFER=2, DONE=3.
REQ-037 The block SHALL be a single module with no sub-modules; the status-word packing is done inline.

Verification
REQ-038 Normal transfer: rx_len_i=4, grant after 3 cycles, words A0..A3 on 4 consecutive dma_req_rd_i -> rd_data_o=A0..A3 each one cycle later, 4 rx_pop_o pulses, then one frame_done_o pulse, then IDLE.
REQ-039 Underrun: rx_len_i=3, rx_valid_i=0 on the 2nd strobe -> err_o=1, exactly one pop, frame_done_o pulse, status read returns bit 13=1 and cnt=2, and err_o=0 after the read.
REQ-040 Grant loss: rx_len_i=5, grant dropped after 2 words -> state REQ, cnt=3, hold_dma_o=0; re-grant completes the remaining 3 words.
REQ-041 Reset: reset_i=0 during XFER with cnt=7 -> all outputs 0 at once and no frame_done_o after release.
REQ-042 Boundaries: rx_len_i=0 is ignored; rx_frame_rdy_i during XFER is ignored; a status read in IDLE returns 0x00000000 after reset.
